// File: rtl/fir_mac_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and default constants for the time-multiplexed
//               FIR sequencer: FSM state encoding, default widths and tap
//               count, and a default low-pass coefficient set.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int c_TAPS = 5;
    localparam int c_DW   = 16;
    localparam int c_CW   = 16;
    localparam int c_OW   = 32;

    // Symmetric low-pass set, Q15-style values.
    localparam logic [15:0] c_DEF_COEF [5] = '{
        16'h0199, 16'h0332, 16'h0666, 16'h0332, 16'h0199
    };

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_mac_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer_if
// Description : Sample-in / result-out valid-ready streams of the FIR
//               sequencer.
//   in_valid/in_ready/in_data    : upstream sample stream (x[n], signed DW)
//   out_valid/out_ready/out_data : downstream result stream (y[n], signed OW)
//   modport slave  : the filter side
//   modport master : the source/sink side
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int DW = c_DW,
    parameter int OW = c_OW
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface : fir_mac_sequencer_if
`default_nettype wire

// File: rtl/fir_mac_sequencer_mac_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_mac_unit
// Description : Shared signed multiply-accumulate datapath with output stage.
//   clr      : zero the accumulator (takes priority over en)
//   en       : acc += coef*sample
//   last     : register the reduced value of (acc + coef*sample) to out_data
//   coef     : signed CW coefficient operand
//   sample   : signed DW sample operand
//   out_data : signed OW result, held until the next 'last'
// Build macro : FIR_SAT_EN - clamp out-of-range results instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_unit #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int OW   = 32,
    parameter int ACCW = 35
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 clr,
    input  wire logic                 en,
    input  wire logic                 last,
    input  wire logic signed [CW-1:0] coef,
    input  wire logic signed [DW-1:0] sample,
    output logic signed [OW-1:0]      out_data
);

    logic signed [DW+CW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_acc_next;
    logic signed [OW-1:0]    w_reduced;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [OW-1:0]    r_out;

    assign w_prod     = coef * sample;
    // Accumulator headroom covers TAPS full-scale products without overflow.
    assign w_acc_next = r_acc + {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};

    generate
        if (ACCW >= OW) begin : g_narrow
`ifdef FIR_SAT_EN
            logic [ACCW-OW:0] w_hi;
            logic             w_in_range;
            // In range when every bit above the OW sign bit matches it.
            assign w_hi       = w_acc_next[ACCW-1:OW-1];
            assign w_in_range = (&w_hi) | ~(|w_hi);
            assign w_reduced  = w_in_range ? w_acc_next[OW-1:0] :
                                w_acc_next[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                                     {1'b0, {(OW-1){1'b1}}};
`else
            assign w_reduced  = w_acc_next[OW-1:0];
`endif
        end else begin : g_wide
            assign w_reduced  = {{(OW-ACCW){w_acc_next[ACCW-1]}}, w_acc_next};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= w_acc_next;
            end
            // The final tap's product is folded in here so the result is
            // registered on the same edge that leaves MAC.
            if (last) begin
                r_out <= w_reduced;
            end
        end
    end

    assign out_data = r_out;

endmodule : fir_mac_unit
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Time-multiplexed FIR filter, y[n] = sum_k coef[k]*x[n-k],
//               using one shared MAC over TAPS cycles per sample.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   s (slave modport)     : in_valid/in_ready/in_data, out_valid/out_ready/
//                           out_data streams
//   coef_we/addr/wdata    : run-time coefficient write port
//   coef_err              : one-cycle pulse when a write was dropped
//   hist_clr              : zero the sample history (IDLE only)
//   busy                  : sequencer is not idle
// Build macro : FIR_SAT_EN - saturating output instead of two's-complement wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS = c_TAPS,
    parameter int DW   = c_DW,
    parameter int CW   = c_CW,
    parameter int OW   = c_OW
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    fir_mac_sequencer_if.slave            s,
    input  wire logic                     coef_we,
    input  wire logic [$clog2(TAPS)-1:0]  coef_addr,
    input  wire logic signed [CW-1:0]     coef_wdata,
    output logic                          coef_err,
    input  wire logic                     hist_clr,
    output logic                          busy
);

    localparam int ACCW = DW + CW + $clog2(TAPS);
    localparam int IW   = $clog2(TAPS);

    localparam logic [1:0] c_S_IDLE = IDLE;
    localparam logic [1:0] c_S_MAC  = MAC;
    localparam logic [1:0] c_S_OUT  = OUT;

    logic [1:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic signed [DW-1:0] r_hist [TAPS];
    logic signed [CW-1:0] r_coef [TAPS];
    logic                 r_coef_err;

    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_mac;
    logic                 w_last;
    logic                 w_addr_ok;
    logic signed [OW-1:0] w_out_data;

    assign w_in_hs   = s.in_valid  && (r_state == c_S_IDLE);
    assign w_out_hs  = s.out_ready && (r_state == c_S_OUT);
    assign w_mac     = (r_state == c_S_MAC);
    assign w_last    = w_mac && (r_idx == IW'(TAPS-1));
    assign w_addr_ok = int'(coef_addr) < TAPS;

    // Sequencer FSM and tap index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_in_hs) begin
                        r_state <= c_S_MAC;
                        r_idx   <= '0;
                    end
                end
                c_S_MAC: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= c_S_OUT;
                    end
                end
                c_S_OUT: begin
                    if (w_out_hs) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Sample history. A clear coinciding with a new sample keeps only the
    // new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) r_hist[k] <= '0;
        end else if (r_state == c_S_IDLE) begin
            if (w_in_hs) begin
                r_hist[0] <= s.in_data;
                for (int k = 1; k < TAPS; k++) begin
                    r_hist[k] <= hist_clr ? '0 : r_hist[k-1];
                end
            end else if (hist_clr) begin
                for (int k = 0; k < TAPS; k++) r_hist[k] <= '0;
            end
        end
    end

    // Coefficient file. Writes during MAC would corrupt the running sum, so
    // they are dropped and flagged along with out-of-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= coef_we && (w_mac || !w_addr_ok);
            if (coef_we && !w_mac && w_addr_ok) begin
                r_coef[coef_addr] <= coef_wdata;
            end
        end
    end

    fir_mac_unit #(
        .DW   (DW),
        .CW   (CW),
        .OW   (OW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_in_hs),
        .en       (w_mac),
        .last     (w_last),
        .coef     (r_coef[r_idx]),
        .sample   (r_hist[r_idx]),
        .out_data (w_out_data)
    );

    assign s.in_ready  = (r_state == c_S_IDLE);
    assign s.out_valid = (r_state == c_S_OUT);
    assign s.out_data  = w_out_data;
    assign coef_err    = r_coef_err;
    assign busy        = (r_state != c_S_IDLE);

endmodule : fir_mac_sequencer
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer. A reference model
//               keeps coefficient and history arrays and computes each output
//               as a plain sum of products, then wraps or clamps it
//               (FIR_SAT_EN) to the output width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int TAPS = c_TAPS;
    localparam int DW   = c_DW;
    localparam int CW   = c_CW;
    localparam int OW   = c_OW;
    localparam int IW   = $clog2(TAPS);

    localparam longint c_MAX = (64'sd1 <<< (OW-1)) - 64'sd1;
    localparam longint c_MIN = -(64'sd1 <<< (OW-1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coef_we = 1'b0;
    logic [IW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          coef_err;
    logic          hist_clr = 1'b0;
    logic          busy;

    fir_mac_sequencer_if #(.DW(DW), .OW(OW)) bus ();

    fir_mac_sequencer #(
        .TAPS (TAPS),
        .DW   (DW),
        .CW   (CW),
        .OW   (OW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (bus),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .hist_clr   (hist_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            m_coef [TAPS];
    int            m_hist [TAPS];
    logic [OW-1:0] m_exp;
    logic [OW-1:0] got;
    logic [OW-1:0] imp_exp [5] = '{32'h00CC7E67, 32'h0198FCCE, 32'h0332F99A,
                                   32'h0198FCCE, 32'h00CC7E67};
`ifdef FIR_SAT_EN
    logic [OW-1:0] sat_exp = 32'h7FFFFFFF;
`else
    logic [OW-1:0] sat_exp = 32'h3FFB0005;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_y();
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
`ifdef FIR_SAT_EN
        if (acc > c_MAX) return {1'b0, {(OW-1){1'b1}}};
        if (acc < c_MIN) return {1'b1, {(OW-1){1'b0}}};
`endif
        return OW'(acc);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
    endtask

    // Coefficient write issued while the sequencer is idle.
    task automatic write_coef(input int addr, input logic [CW-1:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = IW'(addr); coef_wdata = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
        check_eq("coef_err_idle", coef_err, (addr >= TAPS));
        if (addr < TAPS) m_coef[addr] = int'($signed(d));
    endtask

    // Offer one sample; optionally clear history and/or write a coefficient
    // in the same cycle. Returns #1 after the handshake edge.
    task automatic start_sample(input logic [DW-1:0] x, input bit clr,
                                input bit cw, input int ca, input logic [CW-1:0] cd);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = x; hist_clr = clr;
        coef_we = cw; coef_addr = IW'(ca); coef_wdata = cd;
        check_eq("in_ready_idle", bus.in_ready, 1'b1);
        @(posedge clk);
        if (cw && ca < TAPS) m_coef[ca] = int'($signed(cd));
        for (int k = TAPS-1; k > 0; k--) m_hist[k] = clr ? 0 : m_hist[k-1];
        m_hist[0] = int'($signed(x));
        m_exp = model_y();
        #1;
        bus.in_valid = 1'b0; hist_clr = 1'b0; coef_we = 1'b0;
        if (cw) check_eq("coef_err_hs", coef_err, (ca >= TAPS));
    endtask

    // Wait for the result (bounded), check it, stall, then accept it.
    task automatic finish_sample(input int already, input int stall, output logic [OW-1:0] res);
        int lat = already;
        while (!bus.out_valid && lat < 4*TAPS) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, TAPS);
        check_eq("out_data", $unsigned(bus.out_data), m_exp);
        check_eq("out_rdy_busy", {bus.in_ready, busy}, 2'b01);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("hold", {bus.out_valid, bus.in_ready, $unsigned(bus.out_data)}, {2'b10, m_exp});
        end
        res = bus.out_data;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_eq("back_idle", {bus.out_valid, bus.in_ready, busy}, 3'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check_eq("reset_state", {bus.in_ready, bus.out_valid, busy, coef_err}, 4'b1000);
        check_eq("reset_data", $unsigned(bus.out_data), 0);

        // Impulse response with default coefficients; first result stalled.
        for (int k = 0; k < TAPS; k++) write_coef(k, c_DEF_COEF[k]);
        for (int i = 0; i < 5; i++) begin
            start_sample((i == 0) ? 16'h7FFF : 16'h0000, (i == 0), 1'b0, 0, '0);
            finish_sample(0, (i == 0) ? 10 : 0, got);
            check_eq("impulse", got, imp_exp[i]);
        end

        // Coefficient write during MAC is dropped, one-cycle error pulse.
        start_sample(16'h0000, 1'b0, 1'b0, 0, '0);
        coef_we = 1'b1; coef_addr = IW'(2); coef_wdata = 16'h1234;
        @(posedge clk); #1 coef_we = 1'b0;
        check_eq("coef_err_mac", coef_err, 1'b1);
        @(posedge clk); #1;
        check_eq("coef_err_once", coef_err, 1'b0);
        finish_sample(2, 0, got);
        write_coef(7, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            start_sample((i == 0) ? 16'h7FFF : 16'h0000, (i == 0), 1'b0, 0, '0);
            finish_sample(0, 0, got);
        end
        check_eq("coef_kept", got, imp_exp[2]);

        // Reset in the middle of MAC aborts the sample and clears coefficients.
        start_sample(16'h4321, 1'b0, 1'b0, 0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_state", {bus.in_ready, bus.out_valid, busy}, 3'b100);
        check_eq("abort_data", $unsigned(bus.out_data), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        start_sample(16'h7FFF, 1'b0, 1'b0, 0, '0);
        finish_sample(0, 0, got);
        check_eq("zero_coef_out", got, 0);

        // Saturation / wrap at the output width.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'h7FFF);
        for (int i = 0; i < 5; i++) begin
            start_sample(16'h7FFF, (i == 0), 1'b0, 0, '0);
            finish_sample(0, 0, got);
        end
        check_eq("sat_5th", got, sat_exp);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, (1 << IW) - 1), CW'($urandom));
            start_sample(DW'($urandom), ($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 3) == 0), $urandom_range(0, (1 << IW) - 1), CW'($urandom));
            finish_sample(0, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fir_mac_sequencer
`default_nettype wire
